// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
//
// Serial-to-link bridge. A UART byte stream (8N1, LSB first) is assembled into
// 32-bit little-endian words. The words are buffered in a FIFO and sent on a
// transceiver TX parallel path as frames:
//   K28.1 start marker (0x3C, k=0001), 1..FRAME_WORDS data words (k=0000),
//   K28.6 end marker (0xDC, k=0001). Idle words (K28.5, 0xBC, k=0001) fill the
//   gaps between frames.
//
// Parameters
//   CLKS_PER_BIT  sys_clk cycles per UART bit
//   FIFO_DEPTH    word FIFO depth, power of 2
//   FRAME_WORDS   maximum data words per frame, 1..255
//
// Ports
//   sys_clk       system clock
//   sys_rst_n     asynchronous active-low reset, released synchronously upstream
//   rx_serial     UART line, idle high, asynchronous to sys_clk
//   tx_init_done  transceiver TX initialisation complete
//   pll_lock      transceiver PLL locked
//   data_out      transceiver TX data (registered)
//   k_out         K-character flag per byte of data_out (registered)
//   frame_err     one-cycle pulse: stop bit sampled low, byte discarded
//   overflow      sticky: a complete word was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 1041,
    parameter int FIFO_DEPTH   = 64,
    parameter int FRAME_WORDS  = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        rx_serial,
    input  logic        tx_init_done,
    input  logic        pll_lock,
    output logic [31:0] data_out,
    output logic [3:0]  k_out,
    output logic        frame_err,
    output logic        overflow
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] HALF_BIT   = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   LEVEL_ONE  = (PTR_W + 1)'(1);
    localparam logic [7:0]       FRAME_LAST = 8'(FRAME_WORDS);

    localparam logic [31:0] IDLE_WORD = 32'h0000_00BC;  // K28.5
    localparam logic [31:0] SOF_WORD  = 32'h0000_003C;  // K28.1
    localparam logic [31:0] EOF_WORD  = 32'h0000_00DC;  // K28.6
    localparam logic [3:0]  K_LOW     = 4'b0001;
    localparam logic [3:0]  K_NONE    = 4'b0000;

    // -------------------------------------------------------------------------
    // rx_serial synchronizer plus one history flop for falling-edge detection.
    // All flops reset to the idle (high) line level so release of reset does
    // not look like a start bit.
    // -------------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic rx_fall;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours, exactly like hardware.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    // -------------------------------------------------------------------------
    // UART receiver
    // U_WAIT_HIGH holds off after a bad stop bit until the line has returned
    // high, so a break or a stuck-low line cannot retrigger a start.
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP,
        U_WAIT_HIGH
    } uart_state_t;

    uart_state_t      u_state,    u_state_next;
    logic [CNT_W-1:0] u_cnt,      u_cnt_next;
    logic [7:0]       u_shift,    u_shift_next;
    logic [2:0]       u_bit,      u_bit_next;
    logic             byte_valid, byte_valid_next;
    logic             frame_err_next;

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        u_state_next    = u_state;
        u_cnt_next      = u_cnt;
        u_shift_next    = u_shift;
        u_bit_next      = u_bit;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        unique case (u_state)
            U_IDLE: begin
                if (rx_fall) begin
                    u_cnt_next   = HALF_BIT;  // land in the middle of the start bit
                    u_state_next = U_START;
                end
            end

            U_START: begin
                if (u_cnt != '0) begin
                    u_cnt_next = u_cnt - 1'b1;
                end else if (!rx_sync) begin
                    u_cnt_next   = FULL_BIT;
                    u_bit_next   = 3'd0;
                    u_state_next = U_DATA;
                end else begin
                    u_state_next = U_IDLE;    // line already back high: glitch
                end
            end

            U_DATA: begin
                if (u_cnt != '0) begin
                    u_cnt_next = u_cnt - 1'b1;
                end else begin
                    u_shift_next = {rx_sync, u_shift[7:1]};  // LSB arrives first
                    u_cnt_next   = FULL_BIT;
                    u_bit_next   = u_bit + 1'b1;
                    if (u_bit == 3'd7) begin
                        u_state_next = U_STOP;
                    end
                end
            end

            U_STOP: begin
                if (u_cnt != '0) begin
                    u_cnt_next = u_cnt - 1'b1;
                end else if (rx_sync) begin
                    byte_valid_next = 1'b1;
                    u_state_next    = U_IDLE;
                end else begin
                    frame_err_next = 1'b1;
                    u_state_next   = U_WAIT_HIGH;
                end
            end

            U_WAIT_HIGH: begin
                if (rx_sync) begin
                    u_state_next = U_IDLE;
                end
            end

            default: u_state_next = U_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            u_state    <= U_IDLE;
            u_cnt      <= '0;
            u_shift    <= '0;
            u_bit      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            u_state    <= u_state_next;
            u_cnt      <= u_cnt_next;
            u_shift    <= u_shift_next;
            u_bit      <= u_bit_next;
            byte_valid <= byte_valid_next;
            frame_err  <= frame_err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Byte packer: byte n lands in word_buf[8n+7:8n]. The completed word is
    // pushed on the cycle after the fourth byte. byte_idx wraps regardless of
    // whether the FIFO accepts the word, so framing of later words is kept.
    // -------------------------------------------------------------------------
    logic [1:0]  byte_idx;
    logic [31:0] word_buf;
    logic        push;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_idx <= '0;
            word_buf <= '0;
            push     <= 1'b0;
        end else begin
            push <= 1'b0;
            if (byte_valid) begin
                word_buf[{byte_idx, 3'b000} +: 8] <= u_shift;
                byte_idx                          <= byte_idx + 1'b1;
                if (byte_idx == 2'd3) begin
                    push <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Word FIFO, show-ahead: fifo_head is the oldest word whenever non-empty.
    // Pointers wrap naturally because the depth is a power of 2.
    // -------------------------------------------------------------------------
    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   level;
    logic             fifo_full;
    logic             fifo_empty;
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      fifo_head;

    assign fifo_full  = (level == LEVEL_FULL);
    assign fifo_empty = (level == '0);
    assign wr_en      = push & ~fifo_full;
    assign fifo_head  = mem[rd_ptr];

    // NOTE: the storage array has no reset; the pointers and level define which
    // entries are valid, so clearing the array would only cost routing.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= word_buf;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;       // idle, or push and pop together
            endcase
            if (push && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Framer. The output word is chosen by the current state and registered,
    // so data_out trails the state register by one cycle. The only reader of
    // the FIFO is F_DATA, which is entered solely with a non-empty FIFO and
    // left as soon as the pop would empty it, so rd_en never underflows.
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        F_DOWN,
        F_IDLE,
        F_SOF,
        F_DATA,
        F_EOF
    } frame_state_t;

    frame_state_t f_state, f_state_next;
    logic [7:0]   word_cnt, word_cnt_next;
    logic [31:0]  data_next;
    logic [3:0]   k_next;
    logic         link_ok;
    logic         fifo_last;

    assign link_ok   = tx_init_done & pll_lock;
    // The pop in this cycle empties the FIFO unless a push refills it.
    assign fifo_last = (level == LEVEL_ONE) && !wr_en;

    always_comb begin
        f_state_next  = f_state;
        word_cnt_next = word_cnt;
        rd_en         = 1'b0;
        data_next     = IDLE_WORD;
        k_next        = K_LOW;

        unique case (f_state)
            F_DOWN: begin
                if (link_ok) begin
                    f_state_next = F_IDLE;
                end
            end

            F_IDLE: begin
                if (!link_ok) begin
                    f_state_next = F_DOWN;
                end else if (!fifo_empty) begin
                    f_state_next = F_SOF;
                end
            end

            F_SOF: begin
                data_next     = SOF_WORD;
                word_cnt_next = '0;
                f_state_next  = F_DATA;   // a started frame always carries a word
            end

            F_DATA: begin
                data_next     = fifo_head;
                k_next        = K_NONE;   // marker-valued bytes are plain data here
                rd_en         = 1'b1;
                word_cnt_next = word_cnt + 1'b1;
                if ((word_cnt_next == FRAME_LAST) || fifo_last || !link_ok) begin
                    f_state_next = F_EOF;
                end
            end

            F_EOF: begin
                data_next    = EOF_WORD;
                f_state_next = link_ok ? F_IDLE : F_DOWN;
            end

            default: f_state_next = F_DOWN;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            f_state  <= F_DOWN;
            word_cnt <= '0;
            data_out <= IDLE_WORD;
            k_out    <= K_LOW;
        end else begin
            f_state  <= f_state_next;
            word_cnt <= word_cnt_next;
            data_out <= data_next;
            k_out    <= k_next;
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_tx
//
// Directed bench for uart_frame_tx. A monitor records the TX stream as
// {k_out, data_out} tokens, folding each run of idle words into a single idle
// token, so frame structure and the idle gap between frames can be compared
// against hand-built expected streams. Small parameters keep run time short.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_frame_tx;

    localparam int CPB   = 8;
    localparam int DEPTH = 32;
    localparam int FW    = 16;

    localparam logic [35:0] IDLE_T = {4'b0001, 32'h0000_00BC};
    localparam logic [35:0] SOF_T  = {4'b0001, 32'h0000_003C};
    localparam logic [35:0] EOF_T  = {4'b0001, 32'h0000_00DC};

    logic        sys_clk      = 1'b0;
    logic        sys_rst_n    = 1'b0;
    logic        rx_serial    = 1'b1;
    logic        tx_init_done = 1'b0;
    logic        pll_lock     = 1'b0;
    logic [31:0] data_out;
    logic [3:0]  k_out;
    logic        frame_err;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [35:0] obs_q[$];
    logic [35:0] exp_q[$];
    logic        prev_busy  = 1'b0;
    int          fe_count   = 0;
    int          fe_run     = 0;
    int          fe_max_run = 0;

    uart_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .FRAME_WORDS  (FW)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .rx_serial    (rx_serial),
        .tx_init_done (tx_init_done),
        .pll_lock     (pll_lock),
        .data_out     (data_out),
        .k_out        (k_out),
        .frame_err    (frame_err),
        .overflow     (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    // Stream monitor, sampling on the inactive edge.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if ({k_out, data_out} !== IDLE_T) begin
                obs_q.push_back({k_out, data_out});
                prev_busy = 1'b1;
            end else if (prev_busy) begin
                obs_q.push_back(IDLE_T);
                prev_busy = 1'b0;
            end
            if (frame_err) begin
                fe_count++;
                fe_run++;
                if (fe_run > fe_max_run) fe_max_run = fe_run;
            end else begin
                fe_run = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] obs_at(input int i);
        if (i < obs_q.size()) return obs_q[i];
        return 'x;
    endfunction

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, 36'(obs_q.size()), 36'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), obs_at(i), exp_q[i]);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic line(input logic v, input int n);
        rx_serial = v;
        repeat (n) @(posedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) line(b[i], CPB);
        line(stop, CPB);
        line(1'b1, CPB);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    // Test-2 words: the first three carry marker-valued low bytes.
    function automatic logic [31:0] t2_word(input int i);
        logic [7:0] lo;
        case (i)
            0:       lo = 8'h3C;
            1:       lo = 8'hDC;
            2:       lo = 8'hBC;
            default: lo = 8'(i);
        endcase
        return {8'(8'h20 + i), 8'hA5, 8'h5A, lo};
    endfunction

    function automatic logic [31:0] t5_word(input int i);
        return {8'h77, 8'(i), 8'h13, 8'(8'h40 + i)};
    endfunction

    function automatic logic [31:0] t6_word(input int i);
        return {8'hE6, 8'(i), 8'h9C, 8'(8'h60 + i)};
    endfunction

    initial begin
        int fe_before;
        int j;
        int cut;
        logic seen;

        // ---------------- reset state ----------------
        cycles(4);
        check("rst_data", 36'(data_out), 36'h0_0000_00BC);
        check("rst_k", 36'(k_out), 36'h1);
        check("rst_frame_err", 36'(frame_err), 36'h0);
        check("rst_overflow", 36'(overflow), 36'h0);
        sys_rst_n = 1'b1;
        cycles(4);

        // ---------------- 1: one word through the link ----------------
        tx_init_done = 1'b1;
        pll_lock     = 1'b1;
        cycles(4);
        send_word(32'h4433_2211);
        cycles(20);
        exp_q = '{SOF_T, {4'b0000, 32'h4433_2211}, EOF_T, IDLE_T};
        compare_stream("t1");

        // ---------------- 3: bad stop bit ----------------
        fe_before = fe_count;
        send_byte(8'hAA, 1'b0);
        cycles(10);
        check("t3_fe_pulses", 36'(fe_count - fe_before), 36'd1);
        check("t3_fe_width", 36'(fe_max_run), 36'd1);
        send_word(32'h8877_6655);
        cycles(20);
        exp_q = '{SOF_T, {4'b0000, 32'h8877_6655}, EOF_T, IDLE_T};
        compare_stream("t3");

        // ---------------- 4: short low glitch ----------------
        fe_before = fe_count;
        line(1'b0, CPB / 4);
        line(1'b1, 5 * CPB);
        cycles(2);
        check("t4_no_output", 36'(obs_q.size()), 36'd0);
        check("t4_no_fe", 36'(fe_count - fe_before), 36'd0);
        send_word(32'hD4C3_B2A1);
        cycles(20);
        exp_q = '{SOF_T, {4'b0000, 32'hD4C3_B2A1}, EOF_T, IDLE_T};
        compare_stream("t4");

        // ---------------- 2: 20 words, FRAME_WORDS=16 ----------------
        tx_init_done = 1'b0;
        cycles(4);
        for (int i = 0; i < 20; i++) send_word(t2_word(i));
        cycles(10);
        check("t2_held_while_down", 36'(obs_q.size()), 36'd0);
        tx_init_done = 1'b1;
        cycles(100);
        exp_q.push_back(SOF_T);
        for (int i = 0; i < 16; i++) exp_q.push_back({4'b0000, t2_word(i)});
        exp_q.push_back(EOF_T);
        exp_q.push_back(IDLE_T);
        exp_q.push_back(SOF_T);
        for (int i = 16; i < 20; i++) exp_q.push_back({4'b0000, t2_word(i)});
        exp_q.push_back(EOF_T);
        exp_q.push_back(IDLE_T);
        compare_stream("t2");

        // ---------------- 5: overflow ----------------
        pll_lock = 1'b0;
        cycles(4);
        for (int i = 0; i < DEPTH; i++) send_word(t5_word(i));
        cycles(10);
        check("t5_full_no_ovf", 36'(overflow), 36'h0);
        send_word(t5_word(DEPTH));
        cycles(10);
        check("t5_ovf_set", 36'(overflow), 36'h1);
        pll_lock = 1'b1;
        cycles(150);
        exp_q.push_back(SOF_T);
        for (int i = 0; i < 16; i++) exp_q.push_back({4'b0000, t5_word(i)});
        exp_q.push_back(EOF_T);
        exp_q.push_back(IDLE_T);
        exp_q.push_back(SOF_T);
        for (int i = 16; i < DEPTH; i++) exp_q.push_back({4'b0000, t5_word(i)});
        exp_q.push_back(EOF_T);
        exp_q.push_back(IDLE_T);
        compare_stream("t5");
        check("t5_ovf_sticky", 36'(overflow), 36'h1);

        // ---------------- 6: pll_lock drop mid-frame ----------------
        pll_lock = 1'b0;
        cycles(4);
        for (int i = 0; i < 6; i++) send_word(t6_word(i));
        cycles(10);
        pll_lock = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge sys_clk);
            if (obs_q.size() >= 2) seen = 1'b1;
        end
        #1;
        pll_lock = 1'b0;
        check("t6_frame_started", 36'(seen), 36'h1);
        cycles(40);
        check("t6_sof", obs_at(0), SOF_T);
        j = 1;
        while (j < obs_q.size() && j <= 6 && obs_q[j][35:32] == 4'b0000) begin
            check($sformatf("t6_a[%0d]", j - 1), obs_q[j], {4'b0000, t6_word(j - 1)});
            j++;
        end
        cut = j - 1;
        check("t6_cut_in_range", 36'((cut >= 1) && (cut < 6)), 36'h1);
        check("t6_eof", obs_at(j), EOF_T);
        check("t6_idle", obs_at(j + 1), IDLE_T);
        check("t6_quiet_len", 36'(obs_q.size()), 36'(j + 2));
        obs_q.delete();
        pll_lock = 1'b1;
        cycles(40);
        exp_q.push_back(SOF_T);
        for (int i = cut; i < 6; i++) exp_q.push_back({4'b0000, t6_word(i)});
        exp_q.push_back(EOF_T);
        exp_q.push_back(IDLE_T);
        compare_stream("t6_b");

        // ---------------- reset mid-frame ----------------
        pll_lock = 1'b0;
        cycles(4);
        for (int i = 0; i < 4; i++) send_word(t6_word(i + 10));
        cycles(10);
        pll_lock = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge sys_clk);
            if (obs_q.size() >= 2) seen = 1'b1;
        end
        #1;
        check("t7_frame_started", 36'(seen), 36'h1);
        check("t7_busy", 36'({k_out, data_out} !== IDLE_T), 36'h1);
        check("t7_ovf_before", 36'(overflow), 36'h1);
        sys_rst_n = 1'b0;
        #1;
        check("t7_rst_data", 36'(data_out), 36'h0_0000_00BC);
        check("t7_rst_k", 36'(k_out), 36'h1);
        check("t7_rst_ovf", 36'(overflow), 36'h0);
        check("t7_rst_fe", 36'(frame_err), 36'h0);
        cycles(3);
        sys_rst_n = 1'b1;
        cycles(3);
        check("t7_after_rst", {k_out, data_out}, IDLE_T);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
